branch_ctrl: RTL and testbench

Branch resolution controller for the 3-stage pipeline. It holds the architectural condition-code register (z, n, c, v) and accepts branch requests from decode over a valid/ready handshake. It stalls decode while a flag-setting instruction is still in execute, evaluates the condition through the existing checkcc evaluator, and drives the PC redirect and pipeline flush sequence. It also keeps saturating branch statistics for the hazard unit.

---
 rtl/branch_pkg.sv | 34 +++
 rtl/branch_ctrl_if.sv | 26 ++
 rtl/checkcc.sv | 43 ++++
 rtl/branch_ctrl.sv | 141 ++++++++++++++
 tb/tb_branch_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared constants and types for the branch resolution controller
// Purpose: condition encodings, flag bit positions within {v,c,n,z}, FSM state enum.
// Ports: none (package).
package branch_pkg;

    // Flag bit positions in the condition-code word {v,c,n,z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Condition encodings; bit 3 inverts the sense of bits [2:0]
    localparam logic [3:0] COND_AL = 4'b0000;
    localparam logic [3:0] COND_NV = 4'b1000;
    localparam logic [3:0] COND_CC = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b1001;
    localparam logic [3:0] COND_VC = 4'b0010;
    localparam logic [3:0] COND_VS = 4'b1010;
    localparam logic [3:0] COND_EQ = 4'b0011;
    localparam logic [3:0] COND_NE = 4'b1011;
    localparam logic [3:0] COND_GE = 4'b0100;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GT = 4'b0101;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_PL = 4'b0110;
    localparam logic [3:0] COND_MI = 4'b1110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } br_state_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// rtl/branch_ctrl_if.sv - decode-to-branch-controller request handshake
// Purpose: groups the conditional-branch request channel from decode.
// Signals: br_valid/br_cond/br_target driven by decode (master),
//          br_ready returned by the branch controller (slave).
interface branch_ctrl_if #(
    parameter int ADDR_W = 16
) ();
    logic              br_valid;
    logic [3:0]        br_cond;
    logic [ADDR_W-1:0] br_target;
    logic              br_ready;

    modport master (
        output br_valid,
        output br_cond,
        output br_target,
        input  br_ready
    );

    modport slave (
        input  br_valid,
        input  br_cond,
        input  br_target,
        output br_ready
    );
endinterface

// File: rtl/checkcc.sv
// rtl/checkcc.sv - condition-code evaluator
// Purpose: decides whether a 4-bit branch condition holds for a given flag word.
// Ports: cond   - condition encoding
//        flags  - {v,c,n,z}
//        taken  - 1 when the condition holds (x111 never holds)
module checkcc
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);
    logic z;
    logic n;
    logic c;
    logic v;

    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            COND_CC: taken = ~c;
            COND_CS: taken = c;
            COND_VC: taken = ~v;
            COND_VS: taken = v;
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = z | (n != v);
            COND_PL: taken = ~n;
            COND_MI: taken = n;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch resolution controller (flags, hazard stall, redirect, flush)
// Purpose: holds the condition-code register, accepts branches from decode, stalls
//          on pending flag writes, resolves via checkcc, drives PC redirect and flush,
//          and keeps saturating branch statistics.
// Optional: BRANCH_CC_FORWARD_EN - evaluate on cc_in during a cc_we cycle and do not
//           stall when flag_pending and cc_we coincide.
// Ports: clk, rst (sync, active-high)
//        cc_we, cc_in[3:0], flag_pending  - execute-stage flag interface
//        br (branch_ctrl_if.slave)        - br_valid/br_cond/br_target/br_ready
//        stall, flush                     - pipeline control
//        pc_load, pc_target               - PC redirect strobe and address
//        cc_out                           - current condition codes
//        br_total, br_taken               - saturating statistics
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cc_we,
    input  logic [3:0]        cc_in,
    input  logic              flag_pending,
    branch_ctrl_if.slave      br,
    output logic              stall,
    output logic              flush,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic [3:0]        cc_out,
    output logic [CNT_W-1:0]  br_total,
    output logic [CNT_W-1:0]  br_taken
);
    // Counter is loaded with FLUSH_CYCLES-1 so that reaching zero marks the last flush cycle
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    br_state_t   state;
    br_state_t   state_nxt;
    logic [3:0]  flush_cnt;
    logic [3:0]  flush_cnt_nxt;
    logic [3:0]  cc_reg;
    logic [3:0]  eval_flags;
    logic        pending_eff;
    logic        cond_true;
    logic        accept;
    logic        take;

`ifdef BRANCH_CC_FORWARD_EN
    // Flags being written this cycle are already final, so they resolve the hazard
    assign eval_flags  = cc_we ? cc_in : cc_reg;
    assign pending_eff = flag_pending & ~cc_we;
`else
    assign eval_flags  = cc_reg;
    assign pending_eff = flag_pending;
`endif

    checkcc u_checkcc (
        .cond  (br.br_cond),
        .flags (eval_flags),
        .taken (cond_true)
    );

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        br.br_ready   = 1'b0;
        stall         = 1'b0;
        accept        = 1'b0;
        take          = 1'b0;
        case (state)
            IDLE, WAIT: begin
                if (br.br_valid) begin
                    if (pending_eff) begin
                        stall     = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        br.br_ready = 1'b1;
                        accept      = 1'b1;
                        take        = cond_true;
                        if (cond_true) begin
                            state_nxt     = FLUSH;
                            flush_cnt_nxt = FLUSH_LOAD;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (flush_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    flush_cnt_nxt = flush_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Reset abandons any branch: nothing is accepted or stalled while rst is high
        if (rst) begin
            br.br_ready = 1'b0;
            stall       = 1'b0;
            accept      = 1'b0;
            take        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
            cc_reg    <= 4'd0;
            pc_load   <= 1'b0;
            pc_target <= '0;
            br_total  <= '0;
            br_taken  <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            pc_load   <= take;
            if (cc_we) begin
                cc_reg <= cc_in;
            end
            if (take) begin
                pc_target <= br.br_target;
            end
            if (accept && (br_total != CNT_MAX)) begin
                br_total <= br_total + CNT_W'(1);
            end
            if (take && (br_taken != CNT_MAX)) begin
                br_taken <= br_taken + CNT_W'(1);
            end
        end
    end

    assign flush  = (state == FLUSH);
    assign cc_out = cc_reg;
endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - self-checking bench for branch_ctrl
module tb_branch_ctrl;
    localparam int ADDR_W       = 16;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 2;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cc_we = 1'b0;
    logic [3:0]        cc_in = 4'd0;
    logic              flag_pending = 1'b0;
    logic              stall;
    logic              flush;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic [3:0]        cc_out;
    logic [CNT_W-1:0]  br_total;
    logic [CNT_W-1:0]  br_taken;

    branch_ctrl_if #(.ADDR_W(ADDR_W)) bif ();

    always #5 clk = ~clk;

    branch_ctrl #(
        .ADDR_W       (ADDR_W),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cc_we        (cc_we),
        .cc_in        (cc_in),
        .flag_pending (flag_pending),
        .br           (bif.slave),
        .stall        (stall),
        .flush        (flush),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .cc_out       (cc_out),
        .br_total     (br_total),
        .br_taken     (br_taken)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state: flags, remaining flush cycles, redirect, statistics
    int m_cc = 0;
    int m_flush_left = 0;
    int m_pc_load = 0;
    int m_pc_target = 0;
    int m_total = 0;
    int m_taken = 0;
    bit m_ready = 0;

    function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] f);
        bit z, n, c, v, base;
        z = f[0]; n = f[1]; c = f[2]; v = f[3];
        if (cond[2:0] == 3'b111) return 1'b0;
        case (cond[2:0])
            3'd0:    base = 1'b1;
            3'd1:    base = !c;
            3'd2:    base = !v;
            3'd3:    base = z;
            3'd4:    base = (n == v);
            3'd5:    base = !z && (n == v);
            default: base = !n;
        endcase
        return base ^ cond[3];
    endfunction

    // One clock cycle: drive at negedge, check, then advance the model
    task automatic cyc(input bit r, input bit we, input logic [3:0] ci, input bit fp,
                       input bit v, input logic [3:0] cond, input logic [15:0] tgt);
        bit busy, fwd, pend, exp_ready, exp_stall, tk;
        logic [3:0] flags;
        @(negedge clk);
        rst = r; cc_we = we; cc_in = ci; flag_pending = fp;
        bif.br_valid = v; bif.br_cond = cond; bif.br_target = tgt;
        #1;
        busy = (m_flush_left > 0);
        fwd = 1'b0;
`ifdef BRANCH_CC_FORWARD_EN
        fwd = we;
`endif
        pend = fp && !fwd;
        flags = fwd ? ci : 4'(m_cc);
        exp_ready = !r && !busy && v && !pend;
        exp_stall = !r && !busy && v && pend;
        tk = exp_ready && cond_holds(cond, flags);
        check("br_ready", 32'(bif.br_ready), 32'(exp_ready));
        check("stall", 32'(stall), 32'(exp_stall));
        check("flush", 32'(flush), 32'(busy));
        check("pc_load", 32'(pc_load), m_pc_load);
        check("pc_target", 32'(pc_target), m_pc_target);
        check("cc_out", 32'(cc_out), m_cc);
        check("br_total", 32'(br_total), m_total);
        check("br_taken", 32'(br_taken), m_taken);
        m_ready = exp_ready;
        if (r) begin
            m_cc = 0; m_flush_left = 0; m_pc_load = 0; m_pc_target = 0;
            m_total = 0; m_taken = 0;
        end else begin
            if (we) m_cc = int'(ci);
            m_pc_load = tk ? 1 : 0;
            if (tk) m_pc_target = int'(tgt);
            m_flush_left = tk ? FLUSH_CYCLES : (busy ? m_flush_left - 1 : 0);
            if (exp_ready && m_total < CNT_MAX) m_total++;
            if (tk && m_taken < CNT_MAX) m_taken++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 4'd0, 0, 0, 4'd0, 16'd0);
    endtask

    bit          r_r, r_we, r_fp, hv;
    logic [3:0]  hc, r_ci;
    logic [15:0] ht;

    initial begin
        bif.br_valid = 1'b0;
        bif.br_cond = 4'd0;
        bif.br_target = 16'd0;
        repeat (2) @(posedge clk);

        // Reset: flag write during reset is ignored
        cyc(1, 1, 4'b0001, 0, 0, 4'd0, 16'd0);
        cyc(1, 1, 4'b0001, 0, 1, 4'd0, 16'h0011);
        check("t1_ready_in_rst", 32'(bif.br_ready), 32'd0);
        check("t1_cc_rst", 32'(cc_out), 32'd0);
        idle(1);
        check("t1_cc_after", 32'(cc_out), 32'd0);
        check("t1_flush", 32'(flush), 32'd0);
        check("t1_total", 32'(br_total), 32'd0);

        // Not taken
        cyc(0, 0, 4'd0, 0, 1, 4'b0011, 16'h1234);
        check("t2_ready", 32'(bif.br_ready), 32'd1);
        idle(1);
        check("t2_pc_load", 32'(pc_load), 32'd0);
        check("t2_total", 32'(br_total), 32'd1);
        check("t2_taken", 32'(br_taken), 32'd0);

        // Taken with flush
        cyc(0, 1, 4'b0001, 0, 0, 4'd0, 16'd0);
        cyc(0, 0, 4'd0, 0, 1, 4'b0011, 16'h0040);
        check("t3_ready", 32'(bif.br_ready), 32'd1);
        idle(1);
        check("t3_pc_load", 32'(pc_load), 32'd1);
        check("t3_pc_target", 32'(pc_target), 32'h0040);
        check("t3_flush1", 32'(flush), 32'd1);
        idle(1);
        check("t3_flush2", 32'(flush), 32'd1);
        check("t3_pc_load2", 32'(pc_load), 32'd0);
        idle(1);
        check("t3_flush3", 32'(flush), 32'd0);
        check("t3_taken", 32'(br_taken), 32'd1);

        // Flag hazard
        cyc(0, 1, 4'b0000, 0, 0, 4'd0, 16'd0);
        cyc(0, 0, 4'd0, 1, 1, 4'b0100, 16'h0080);
        check("t4_stall1", 32'(stall), 32'd1);
        cyc(0, 1, 4'b1010, 1, 1, 4'b0100, 16'h0080);
`ifdef BRANCH_CC_FORWARD_EN
        check("t4_fwd_ready", 32'(bif.br_ready), 32'd1);
        check("t4_fwd_nostall", 32'(stall), 32'd0);
`else
        check("t4_stall2", 32'(stall), 32'd1);
        cyc(0, 0, 4'd0, 0, 1, 4'b0100, 16'h0080);
        check("t4_ready", 32'(bif.br_ready), 32'd1);
        check("t4_stall3", 32'(stall), 32'd0);
`endif
        idle(1);
        check("t4_pc_load", 32'(pc_load), 32'd1);
        check("t4_pc_target", 32'(pc_target), 32'h0080);
        idle(3);

        // Signed compares with n only
        cyc(0, 1, 4'b0010, 0, 0, 4'd0, 16'd0);
        cyc(0, 0, 4'd0, 0, 1, 4'b1100, 16'h0100);
        idle(1);
        check("t5_lt_taken", 32'(pc_load), 32'd1);
        idle(2);
        cyc(0, 0, 4'd0, 0, 1, 4'b0101, 16'h0200);
        idle(1);
        check("t5_gt_not", 32'(pc_load), 32'd0);
        cyc(0, 0, 4'd0, 0, 1, 4'b0111, 16'h0300);
        idle(1);
        check("t5_x111_not", 32'(pc_load), 32'd0);

        // Saturation, then reset in the middle of FLUSH
        cyc(1, 0, 4'd0, 0, 0, 4'd0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 4'd0, 0, 1, 4'b0000, 16'(i + 1));
            idle(2);
        end
        check("t6_total_sat", 32'(br_total), 32'd3);
        check("t6_taken_sat", 32'(br_taken), 32'd3);
        cyc(0, 0, 4'd0, 0, 1, 4'b0000, 16'h0abc);
        idle(1);
        check("t6_flush_on", 32'(flush), 32'd1);
        cyc(1, 0, 4'd0, 0, 0, 4'd0, 16'd0);
        idle(1);
        check("t6_flush_off", 32'(flush), 32'd0);
        check("t6_total_rst", 32'(br_total), 32'd0);
        check("t6_taken_rst", 32'(br_taken), 32'd0);
        check("t6_pc_load", 32'(pc_load), 32'd0);

        // Randomized traffic, branch held stable until accepted
        hv = 1'b0;
        hc = 4'd0;
        ht = 16'd0;
        for (int i = 0; i < 3000; i++) begin
            r_r  = ($urandom_range(0, 63) == 0);
            r_we = ($urandom_range(0, 3) == 0);
            r_fp = ($urandom_range(0, 2) == 0);
            r_ci = 4'($urandom);
            if (!hv) begin
                hv = 1'($urandom_range(0, 1));
                hc = 4'($urandom);
                ht = 16'($urandom);
            end
            cyc(r_r, r_we, r_ci, r_fp, hv, hc, ht);
            if (r_r || m_ready) hv = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
